// File: rtl/v15_pulse_generator.sv
// Synthetic detector pulse source: baseline, linear rise, exponential decay, holdoff.
// Define V15_PULSE_PILEUP_EN to let a trigger during decay stack a new pulse.
module v15_pulse_generator #(
    parameter int SIZE_ADC_DATA = 12,
    parameter int FRAC_BITS     = 8,
    parameter int RISE_SHIFT    = 2,
    parameter int DECAY_SHIFT   = 4,
    parameter int BASELINE      = 100,
    parameter int HOLDOFF_LEN   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [SIZE_ADC_DATA-1:0] amplitude,
    output logic                     busy,
    output logic                     pulse_done,
    output logic [SIZE_ADC_DATA-1:0] output_data,
    output logic [7:0]               missed_cnt
);

    localparam int YW = SIZE_ADC_DATA + FRAC_BITS;
    localparam int RW = RISE_SHIFT + 1;
    localparam int HW = $clog2(HOLDOFF_LEN + 1);
    localparam int RISE_LEN = 1 << RISE_SHIFT;
    localparam longint OMAX = (64'd1 << SIZE_ADC_DATA) - 1;
    localparam longint BASE_CLIP = (BASELINE > OMAX) ? OMAX : BASELINE;
    localparam logic [SIZE_ADC_DATA:0] BASE_EXT = (SIZE_ADC_DATA+1)'(BASE_CLIP);

    typedef enum logic [1:0] {IDLE, RISE, DECAY, HOLDOFF} state_t;

    state_t             state, state_next;
    logic [YW-1:0]      y, y_next, step, step_next, step_load;
    logic [YW-1:0]      y_dec, y_sat;
    logic [YW:0]        y_sum;
    logic [RW-1:0]      rise_cnt, rise_cnt_next;
    logic [HW-1:0]      hold_cnt, hold_cnt_next;
    logic [SIZE_ADC_DATA:0] out_sum;
    logic               accept, missed;

    assign step_load = YW'(amplitude) << (FRAC_BITS - RISE_SHIFT);
    assign y_sum     = {1'b0, y} + {1'b0, step};
    assign y_sat     = y_sum[YW] ? '1 : y_sum[YW-1:0];
    assign y_dec     = y - (y >> DECAY_SHIFT);
    assign out_sum   = BASE_EXT + {1'b0, y[YW-1:FRAC_BITS]};

`ifdef V15_PULSE_PILEUP_EN
    assign accept = start && (state == IDLE || state == DECAY);
`else
    assign accept = start && (state == IDLE);
`endif
    assign missed = start && !accept;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            y           <= '0;
            step        <= '0;
            rise_cnt    <= '0;
            hold_cnt    <= '0;
            missed_cnt  <= '0;
            output_data <= BASE_EXT[SIZE_ADC_DATA-1:0];
        end else begin
            state       <= state_next;
            y           <= y_next;
            step        <= step_next;
            rise_cnt    <= rise_cnt_next;
            hold_cnt    <= hold_cnt_next;
            output_data <= out_sum[SIZE_ADC_DATA] ? '1 : out_sum[SIZE_ADC_DATA-1:0];
            if (missed && missed_cnt != 8'hFF)
                missed_cnt <= missed_cnt + 8'd1;
        end
    end

    always_comb begin
        state_next    = state;
        y_next        = y;
        step_next     = step;
        rise_cnt_next = rise_cnt;
        hold_cnt_next = hold_cnt;
        unique case (state)
            IDLE: y_next = '0;
            RISE: begin
                y_next        = y_sat;
                rise_cnt_next = rise_cnt + 1'b1;
                if (rise_cnt == RW'(RISE_LEN - 1))
                    state_next = DECAY;
            end
            DECAY: begin
                // A stacked trigger holds y for one cycle and rises from there
                if (accept) begin
                    y_next = y;
                end else if (y_dec[YW-1:FRAC_BITS] == '0) begin
                    y_next        = '0;
                    hold_cnt_next = '0;
                    state_next    = HOLDOFF;
                end else begin
                    y_next = y_dec;
                end
            end
            HOLDOFF: begin
                y_next        = '0;
                hold_cnt_next = hold_cnt + 1'b1;
                if (hold_cnt == HW'(HOLDOFF_LEN - 1))
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            step_next     = step_load;
            rise_cnt_next = '0;
            state_next    = RISE;
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        pulse_done = (state == HOLDOFF) && (hold_cnt == '0);
    end

endmodule
